// File: rtl/imm_rot_encoder_pkg.sv
// Shared definitions for the rotate-immediate encoder: FSM encodings, candidate
// limits and the layout of the 12-bit shift_operand field.
package imm_rot_encoder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic [4:0] CAND_LAST_PLAIN = 5'd15;
  localparam logic [4:0] CAND_LAST_INV   = 5'd31;

  typedef struct packed {
    logic [3:0] rot;
    logic [7:0] imm8;
  } shift_op_t;

  // Candidates 16..31 retry the search on the complemented constant.
  function automatic logic [31:0] cand_operand(input logic [31:0] val,
                                               input logic [4:0]  cand);
    return cand[4] ? ~val : val;
  endfunction

endpackage

// File: rtl/imm_rot_check.sv
// Tests one rotation: rotates the operand left by 2r and reports whether the
// result fits in the low 8 bits, together with that 8-bit immediate.
module imm_rot_check (
  input  logic [31:0] operand,
  input  logic [3:0]  r,
  output logic        hit,
  output logic [7:0]  imm8
);

  logic [5:0]  sh_left;
  logic [5:0]  sh_right;
  logic [31:0] rotated;

  assign sh_left  = {1'b0, r, 1'b0};
  assign sh_right = 6'd32 - sh_left;

  // A right shift by the full word width yields zero, so r = 0 is a plain pass-through.
  assign rotated = (operand << sh_left) | (operand >> sh_right);

  assign hit  = ~|rotated[31:8];
  assign imm8 = rotated[7:0];

endmodule

// File: rtl/imm_rot_encoder.sv
// Multi-cycle encoder from a 32-bit constant to the ARM rotate-immediate field
// {rot, imm8}; one rotation is tried per clock, optionally on ~value as well.
module imm_rot_encoder
  import imm_rot_encoder_pkg::*;
#(
  parameter bit ALLOW_INV = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] value,
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic        inverted,
  output logic [11:0] shift_operand
);

  localparam logic [4:0] CAND_LAST = ALLOW_INV ? CAND_LAST_INV : CAND_LAST_PLAIN;

  state_e      state_q;
  logic [31:0] val_q;
  logic [4:0]  cand_q;
  logic [4:0]  cand_d;
  logic        busy_q;
  logic        done_q;
  logic        found_q;
  logic        inv_q;
  shift_op_t   so_q;

  logic [31:0] operand;
  logic        hit;
  logic [7:0]  imm8;
  logic        last_cand;

  assign operand   = cand_operand(val_q, cand_q);
  assign last_cand = (cand_q == CAND_LAST);
  assign cand_d    = cand_q + 5'd1;

  imm_rot_check u_check (
    .operand (operand),
    .r       (cand_q[3:0]),
    .hit     (hit),
    .imm8    (imm8)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      val_q   <= 32'h0;
      cand_q  <= 5'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      found_q <= 1'b0;
      inv_q   <= 1'b0;
      so_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            val_q   <= value;
            cand_q  <= 5'd0;
            busy_q  <= 1'b1;
            found_q <= 1'b0;
            inv_q   <= 1'b0;
            so_q    <= '0;
            state_q <= SEARCH;
          end
        end

        SEARCH: begin
          // Terminal-miss detection wins over increment, so cand_q never wraps.
          if (hit) begin
            found_q   <= 1'b1;
            inv_q     <= cand_q[4];
            so_q.rot  <= cand_q[3:0];
            so_q.imm8 <= imm8;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= DONE;
          end else if (last_cand) begin
            found_q <= 1'b0;
            inv_q   <= 1'b0;
            so_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            cand_q <= cand_d;
          end
        end

        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign found         = found_q;
  assign inverted      = inv_q;
  assign shift_operand = so_q;

endmodule

// File: doc/imm_rot_encoder.md
Name: imm_rot_encoder

Overview:
- Multi-cycle encoder that turns a 32-bit constant into the ARM data-processing rotate-immediate field shift_operand[11:0] = {rot[3:0], imm8[7:0]}, where value = imm8 ROR (2*rot).
- Used by the instruction-memory builder and the assembler-side test infrastructure. It is the inverse of the Operand2 immediate decode in the EXE stage.
- Searches one rotation per clock. It can optionally retry with the bitwise complement so MOV can be rewritten as MVN.

Parameters:
- ALLOW_INV, 1, 1 enables the complemented second pass (candidates 16..31); 0 restricts the search to candidates 0..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- value  input  32  constant to encode; sampled on the edge that accepts start.
- busy  output  1  high from the accept edge until done is asserted.
- done  output  1  one-cycle pulse when the result is valid.
- found  output  1  1 = an encoding exists; valid from done until the next accept.
- inverted  output  1  1 = shift_operand encodes ~value.
- shift_operand  output  12  {rot, imm8}; all zero when found = 0.

Behaviour:
- Reset, asynchronous while rst = 0:
  - state = IDLE.
  - busy, done, found, inverted = 0; shift_operand = 12'h000; internal value register and candidate counter = 0.
  - Reset mid-search aborts the search with no done pulse.
- States: IDLE, SEARCH, DONE.
- IDLE:
  - start = 1 at edge E0 latches value into val_q, sets cand = 0, enters SEARCH, and drives busy = 1 after E0.
  - start = 0 stays in IDLE.
- SEARCH, candidate k = cand[4:0]:
  - Operand is val_q for k < 16, else ~val_q; r = k[3:0].
  - Test: t = operand ROL (2*r). A hit means t[31:8] == 0. Rotation amount 0 means no rotation.
  - Candidate k is evaluated on edge E(k+1).
  - On a hit at E(k+1): found = 1, inverted = k[4], shift_operand = {r, t[7:0]}, go to DONE.
  - Miss with k == 15 and ALLOW_INV == 0, or miss with k == 31: found = 0, inverted = 0, shift_operand = 0, go to DONE.
  - Any other miss: cand = k + 1.
  - The first hit wins, so the smallest rot is always preferred, and a plain encoding always beats an inverted one.
- DONE: lasts exactly one cycle.
  - done = 1 and busy = 0 during that cycle.
  - Next edge returns to IDLE with done = 0.
  - found, inverted and shift_operand hold until the next accepted start.
- Latency: a hit on candidate k gives done high in the cycle after E(k+1).
  - Best case: done in the cycle after E1.
  - Worst case: done after E32, or after E16 when ALLOW_INV = 0.
- start while busy or in the DONE cycle is ignored and is not queued.
- value changes after the accept edge have no effect.
- The counter never wraps past 31; terminal-miss detection precedes increment.
- Result outputs are registered and never change while busy = 1. Outputs of the previous result persist until an accept edge clears them.
  - found, inverted and shift_operand are cleared to 0 on the accept edge.

Decomposition:
- Shared include/package holds:
  - state encodings IDLE = 2'd0, SEARCH = 2'd1, DONE = 2'd2;
  - localparam CAND_LAST_PLAIN = 5'd15 and CAND_LAST_INV = 5'd31.
- One combinational sub-module, imm_rot_check:
  - inputs: operand[31:0], r[3:0];
  - outputs: hit and imm8[7:0];
  - it computes the ROL by 2r and the upper-24-zero test.
- The top level holds the FSM, candidate counter and result registers.

Test Plan:
- value = 32'h0000_0000, ALLOW_INV = 1 -> done after E1, found = 1, inverted = 0, shift_operand = 12'h000.
- value = 32'hFF00_0000 -> hit at candidate 4, done after E5, shift_operand = 12'h4FF, inverted = 0.
- value = 32'h0000_0104 -> hit at candidate 15, done after E16, shift_operand = 12'hF41.
- value = 32'hFFFF_FF00:
  - with ALLOW_INV = 1 -> candidate 16, done after E17, found = 1, inverted = 1, shift_operand = 12'h0FF;
  - with ALLOW_INV = 0 -> done after E16, found = 0, shift_operand = 0.
- value = 32'h0000_0102, ALLOW_INV = 1 -> done after E32, found = 0, inverted = 0, shift_operand = 0. A second start pulse at E5 is ignored: no extra done and busy stays high.
- Reset and protocol corners:
  - start with 32'h0000_0104, drop rst low at E8 -> outputs zero immediately and no done pulse;
  - after rst rises, start with 32'h0000_00AB -> done after E1 with shift_operand = 12'h0AB.
